// File: rtl/hft_pkg.sv
// Shared types and constants for the market-data receive path.
// Holds the default frame sync byte, the payload length, the framer state
// encoding and the packed quote record shared with rx_mux.
// Optional feature macro: RX_CHECKSUM_EN adds the CSUM framer state.
package hft_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_BYTES     = 16;

`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {ST_HUNT, ST_ADDR, ST_PAYLOAD, ST_CSUM} rx_state_e;
`else
  typedef enum logic [1:0] {ST_HUNT, ST_ADDR, ST_PAYLOAD} rx_state_e;
`endif

  // Field order matches wire order, so {addr, payload} packs directly.
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] buyprice;
    logic [31:0] sellprice;
    logic [31:0] buyvol;
    logic [31:0] sellvol;
  } quote_rec_t;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte-in / record-out bundle of uart_rx_framer.
//   byte_in/byte_dv : byte stream from the UART byte receiver
//   addr, rx_*      : committed quote record, rx_dv one-cycle strobe
//   frame_err       : one-cycle pulse per discarded frame
//   err_cnt         : saturating discarded-frame count
// master = byte source / record consumer, slave = the framer.
interface uart_rx_framer_if;
  import hft_pkg::*;

  logic [7:0]  byte_in;
  logic        byte_dv;
  logic [7:0]  addr;
  logic [31:0] rx_buyprice;
  logic [31:0] rx_sellprice;
  logic [31:0] rx_buyvol;
  logic [31:0] rx_sellvol;
  logic        rx_dv;
  logic        frame_err;
  logic [15:0] err_cnt;

  modport master (
    output byte_in, byte_dv,
    input  addr, rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol,
    input  rx_dv, frame_err, err_cnt
  );

  modport slave (
    input  byte_in, byte_dv,
    output addr, rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol,
    output rx_dv, frame_err, err_cnt
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap watchdog for the framer.
//   clk, reset_n : clock, async active-low reset
//   clear        : byte strobe, restarts the gap count
//   enable       : framer is inside a frame
//   expired      : one-cycle pulse when the count reaches TIMEOUT_CYCLES-1
// A clear in the expiry cycle suppresses the pulse, so a late-but-in-time
// byte always wins over the timeout.
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        cnt <= '0;
    else if (clear || !enable || cnt == LAST) cnt <= '0;
    else                                 cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Byte-to-record assembler: hunts for SYNC_BYTE, collects addr plus 16
// big-endian payload bytes (buyprice, sellprice, buyvol, sellvol), and
// commits a whole quote record with a one-cycle rx_dv. Stalled frames
// (and, with RX_CHECKSUM_EN, frames whose trailing XOR byte mismatches)
// are dropped with a frame_err pulse and counted in err_cnt.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : byte stream in, record / error status out
// Optional feature macro: RX_CHECKSUM_EN (19-byte frames with XOR check).
module uart_rx_framer
  import hft_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_rx_framer_if.slave bus
);

  localparam int IW = $clog2(PAYLOAD_BYTES);

  rx_state_e      state, state_n;
  logic [IW-1:0]  idx;
  logic [7:0]     sh_addr;
  logic [127:0]   sh_data;
  logic [127:0]   shift_data;
  logic [127:0]   commit_data;
  quote_rec_t     rec_q;
  logic           rx_dv_q, frame_err_q;
  logic [15:0]    err_cnt_q;
  logic           commit, err, expired, last_byte;
  logic [7:0]     byte_in;
  logic           byte_dv;
`ifdef RX_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  assign byte_in = bus.byte_in;
  assign byte_dv = bus.byte_dv;

  rx_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (byte_dv),
    .enable  (state != ST_HUNT),
    .expired (expired)
  );

  assign last_byte  = (idx == IW'(PAYLOAD_BYTES - 1));
  assign shift_data = {sh_data[119:0], byte_in};
  // Without a checksum the commit happens on the last payload byte itself,
  // before it has landed in the shadow register.
  assign commit_data = (state == ST_PAYLOAD) ? shift_data : sh_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_HUNT;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    err     = 1'b0;
    if (byte_dv) begin
      case (state)
        ST_HUNT:    if (byte_in == SYNC_BYTE) state_n = ST_ADDR;
        ST_ADDR:    state_n = ST_PAYLOAD;
        ST_PAYLOAD: if (last_byte) begin
`ifdef RX_CHECKSUM_EN
                      state_n = ST_CSUM;
`else
                      state_n = ST_HUNT;
                      commit  = 1'b1;
`endif
                    end
`ifdef RX_CHECKSUM_EN
        ST_CSUM: begin
          state_n = ST_HUNT;
          if (byte_in == csum) commit = 1'b1;
          else                 err    = 1'b1;
        end
`endif
        default:    state_n = ST_HUNT;
      endcase
    end else if (expired) begin
      state_n = ST_HUNT;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      sh_addr     <= '0;
      sh_data     <= '0;
      rec_q       <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
`ifdef RX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      rx_dv_q     <= commit;
      frame_err_q <= err;
      if (err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      // Packed record layout is {addr, buyprice, sellprice, buyvol, sellvol}.
      if (commit) rec_q <= {sh_addr, commit_data};
      if (byte_dv) begin
        if (state == ST_ADDR) begin
          sh_addr <= byte_in;
          idx     <= '0;
`ifdef RX_CHECKSUM_EN
          csum    <= byte_in;
`endif
        end else if (state == ST_PAYLOAD) begin
          sh_data <= shift_data;
          idx     <= idx + IW'(1);
`ifdef RX_CHECKSUM_EN
          csum    <= csum ^ byte_in;
`endif
        end
      end
    end
  end

  assign bus.addr         = rec_q.addr;
  assign bus.rx_buyprice  = rec_q.buyprice;
  assign bus.rx_sellprice = rec_q.sellprice;
  assign bus.rx_buyvol    = rec_q.buyvol;
  assign bus.rx_sellvol   = rec_q.sellvol;
  assign bus.rx_dv        = rx_dv_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.err_cnt      = err_cnt_q;

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Byte-to-record assembler between the UART byte receiver and `rx_mux`. Hunts for a sync byte, collects an address byte and four 32-bit big-endian market fields, optionally verifies a checksum, and presents a complete quote record with a one-cycle `rx_dv` strobe. Partial, stalled or corrupt frames are discarded and counted, so downstream stages only ever see whole records.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 100000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `byte_in` in 8: received byte from the UART byte receiver.
- `byte_dv` in 1: one-cycle strobe; `byte_in` is valid this cycle.
- `addr` out 8: record address.
- `rx_buyprice` out 32: buy price.
- `rx_sellprice` out 32: sell price.
- `rx_buyvol` out 32: buy volume.
- `rx_sellvol` out 32: sell volume.
- `rx_dv` out 1: one-cycle pulse; the outputs above hold a new valid record.
- `frame_err` out 1: one-cycle pulse; a frame was discarded.
- `err_cnt` out 16: saturating count of discarded frames.

## Operation
- Frame on the wire: `SYNC_BYTE`, addr, then 16 payload bytes. Payload order is buyprice, sellprice, buyvol, sellvol. Each field is sent MSB first. With checksum enabled, one checksum byte follows.
- State machine:
  - HUNT: discards every byte that is not `SYNC_BYTE`. On `SYNC_BYTE`, goes to ADDR.
  - ADDR: the next byte is latched into the shadow address and the running XOR is seeded with it. Goes to PAYLOAD with byte index = 0.
  - PAYLOAD: each byte shifts into the 128-bit shadow register and is XORed into the running checksum. After index 15, goes to CSUM if checksum is enabled, otherwise to commit.
  - CSUM: if the byte equals the running XOR, commit. Otherwise pulse `frame_err` and return to HUNT.
  - Commit: the shadow registers are copied to the outputs, `rx_dv` pulses, and the machine returns to HUNT.
- Inside a frame, `SYNC_BYTE` values are ordinary data. There is no resynchronisation mid-frame.
- Outputs change only on commit. They hold their value between records and after an error.
- Gap timer:
  - Cleared on every `byte_dv`.
  - Counts while the state is not HUNT.
  - On reaching `TIMEOUT_CYCLES-1`: pulse `frame_err` and return to HUNT.
- If `byte_dv` and the timeout occur in the same cycle, the byte wins: it is accepted and the timer is cleared.
- `err_cnt` increments on each `frame_err` and saturates at 16'hFFFF.

## Timing
- Reset values:
  - All data outputs 0.
  - `rx_dv` = 0, `frame_err` = 0, `err_cnt` = 0.
  - State is HUNT; timer and index are 0.
- Latency: `rx_dv` and the new output values appear in the cycle after the `byte_dv` of the final frame byte.
- Back-to-back frames: a `SYNC_BYTE` strobe in the cycle immediately after the final byte is accepted.
- `frame_err` is a registered pulse, asserted one cycle after the triggering byte or timeout.
- `rx_dv` and `frame_err` never assert in the same cycle.
- Reset asserted mid-frame:
  - The partial frame is lost and the state returns to HUNT.
  - It does not count as an error and does not pulse `frame_err`.
- No back-pressure; the consumer must accept a record within one cycle.

## Configuration
- `RX_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - Frame is 19 bytes; the checksum is the XOR of addr and the 16 payload bytes.
  - A mismatch discards the frame and pulses `frame_err`.
- `RX_CHECKSUM_EN` undefined:
  - The CSUM state and the XOR logic are removed.
  - Frame is 18 bytes; commit happens after payload byte 15.
  - `frame_err` comes from timeout only.

## Structure
- `hft_pkg` holds:
  - The `SYNC_BYTE` default.
  - `PAYLOAD_BYTES` = 16.
  - The framer state enum.
  - A packed quote-record struct (addr plus four 32-bit fields), shared with `rx_mux`.
- One sub-module, `rx_gap_timer`:
  - Inputs: clear (`byte_dv`) and enable (state != HUNT).
  - Output: a one-cycle `expired` pulse at `TIMEOUT_CYCLES-1`.

## Test plan
- Good frame, checksum enabled. Send A5 01 00000064 00000065 000003E8 000001F4 1E. Expect:
  - `rx_dv` pulse; `addr`=01, buyprice=100, sellprice=101, buyvol=1000, sellvol=500.
  - `err_cnt`=0.
- Same frame with checksum 1F: no `rx_dv`, one `frame_err` pulse, `err_cnt`=1, outputs unchanged.
- Noise 00 FF 37 before the frame: no pulses; frame decodes as in the first scenario.
- Stall after 5 payload bytes for `TIMEOUT_CYCLES` clocks: `frame_err` pulses. A following full frame decodes correctly.
- Payload containing A5 bytes (buyprice A5A5A5A5): decodes intact, no resync.
- Reset asserted mid-payload, then a full frame: outputs return to 0, `err_cnt` stays 0, the new frame decodes. Also check that a byte arriving exactly in the timeout cycle is accepted.
